// File: rtl/ula_pkg.sv
// Shared definitions for the ULA and its controller: opcodes, controller
// state encoding and the default datapath width.
package ula_pkg;

  localparam int ULA_WIDTH = 8;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ula_state_t;

endpackage

// File: rtl/ula_ctrl_wait.sv
// Fixed-latency counter: cleared on start, counts while run is high, and
// raises hit once LAT edges have elapsed since the clear.
module ula_ctrl_wait #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic hit
);

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  logic [2:0] wcnt;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 3'd0;
    end else if (start) begin
      wcnt <= 3'd0;
    end else if (run && !hit) begin
      wcnt <= wcnt + 3'd1;
    end
  end

  assign hit = (wcnt == LAT_CNT);

endmodule

// File: rtl/ula_ctrl.sv
// Initiator-side controller for the ULA: accepts one request, drives the
// registered operands, waits LAT edges, captures the result and returns it.
// Optional result flags are enabled with the ULA_CTRL_FLAGS_EN macro.
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [2:0]       ula_op,
  input  logic [WIDTH-1:0] ula_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic [2:0]       rsp_op,
  output logic [15:0]      op_count
`ifdef ULA_CTRL_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_neg
`endif
);

  ula_state_t state, state_nxt;
  logic       hit;
  logic       in_wait;
  logic       accept;
  logic       capture;
  logic       rsp_fire;

  assign in_wait  = (state == WAIT);
  assign accept   = req_valid && req_ready;
  assign capture  = in_wait && hit;
  assign rsp_fire = rsp_valid && rsp_ready;

  ula_ctrl_wait #(
    .LAT (LAT)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .run   (in_wait),
    .hit   (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = WAIT;
      WAIT:    if (hit)      state_nxt = DONE;
      DONE:    if (rsp_fire) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // req_ready is held low while reset is asserted so no request is taken
  // on the edge that releases reset.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    req_ready = !rst;
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ula_a  <= '0;
      ula_b  <= '0;
      ula_op <= 3'd0;
    end else if (accept) begin
      ula_a  <= req_a;
      ula_b  <= req_b;
      ula_op <= req_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_s  <= '0;
      rsp_op <= 3'd0;
`ifdef ULA_CTRL_FLAGS_EN
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
`endif
    end else if (capture) begin
      rsp_s  <= ula_s;
      rsp_op <= ula_op;
`ifdef ULA_CTRL_FLAGS_EN
      rsp_zero <= (ula_s == '0);
      rsp_neg  <= ula_s[WIDTH-1];
`endif
    end
  end

  // Counts completed handshakes only; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= 16'd0;
    end else if (rsp_fire) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ula_ctrl.sv
// Scoreboard bench for ula_ctrl: a behavioural ULA with one-edge latency
// drives the main instance; two extra instances (LAT=0, LAT=3) run streams.
module tb_ula_ctrl;
  import ula_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ula_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      ULA_ADD: return a + b;
      ULA_SUB: return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // ---------------- main instance (LAT=1) ----------------
  logic         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W-1:0] req_a, req_b, ula_a, ula_b, ula_s, rsp_s;
  logic [2:0]   req_op, ula_op, rsp_op;
  logic [15:0]  op_count;
`ifdef ULA_CTRL_FLAGS_EN
  logic         rsp_zero, rsp_neg;
`endif

  ula_ctrl #(.WIDTH(W), .LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .ula_s(ula_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_op(rsp_op), .op_count(op_count)
`ifdef ULA_CTRL_FLAGS_EN
    , .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
`endif
  );

  // ULA model with a one-edge result latency
  logic [W-1:0] s_pipe;
  always @(posedge clk or posedge rst) begin
    if (rst) s_pipe <= '0;
    else     s_pipe <= ula_f(ula_a, ula_b, ula_op);
  end
  assign ula_s = s_pipe;

  // ---------------- stream instances (LAT=0, LAT=3) ----------------
  logic         aux_run = 1'b0;
  logic         l0_req_ready, l0_rsp_valid, l3_req_ready, l3_rsp_valid;
  logic [W-1:0] l0_ula_a, l0_ula_b, l0_rsp_s, l3_ula_a, l3_ula_b, l3_rsp_s;
  logic [2:0]   l0_ula_op, l0_rsp_op, l3_ula_op, l3_rsp_op;
  logic [15:0]  l0_op_count, l3_op_count;
`ifdef ULA_CTRL_FLAGS_EN
  logic         l0_zero, l0_neg, l3_zero, l3_neg;
`endif

  ula_ctrl #(.WIDTH(W), .LAT(0)) u_l0 (
    .clk(clk), .rst(rst),
    .req_valid(aux_run), .req_ready(l0_req_ready),
    .req_a(8'd3), .req_b(8'd4), .req_op(ULA_ADD),
    .ula_a(l0_ula_a), .ula_b(l0_ula_b), .ula_op(l0_ula_op),
    .ula_s(ula_f(l0_ula_a, l0_ula_b, l0_ula_op)),
    .rsp_valid(l0_rsp_valid), .rsp_ready(1'b1),
    .rsp_s(l0_rsp_s), .rsp_op(l0_rsp_op), .op_count(l0_op_count)
`ifdef ULA_CTRL_FLAGS_EN
    , .rsp_zero(l0_zero), .rsp_neg(l0_neg)
`endif
  );

  ula_ctrl #(.WIDTH(W), .LAT(3)) u_l3 (
    .clk(clk), .rst(rst),
    .req_valid(aux_run), .req_ready(l3_req_ready),
    .req_a(8'd3), .req_b(8'd4), .req_op(ULA_ADD),
    .ula_a(l3_ula_a), .ula_b(l3_ula_b), .ula_op(l3_ula_op),
    .ula_s(ula_f(l3_ula_a, l3_ula_b, l3_ula_op)),
    .rsp_valid(l3_rsp_valid), .rsp_ready(1'b1),
    .rsp_s(l3_rsp_s), .rsp_op(l3_rsp_op), .op_count(l3_op_count)
`ifdef ULA_CTRL_FLAGS_EN
    , .rsp_zero(l3_zero), .rsp_neg(l3_neg)
`endif
  );

  int   l0_acc = -1, l3_acc = -1;
  logic l0_pv = 1'b0, l3_pv = 1'b0;

  always @(negedge clk) begin
    if (aux_run) begin
      if (l0_rsp_valid && !l0_pv) begin
        check("l0_latency", cyc - l0_acc, 1);
        check("l0_rsp_s", l0_rsp_s, 8'd7);
      end
      if (l0_req_ready) begin
        if (l0_acc >= 0) check("l0_accept_spacing", cyc + 1 - l0_acc, 3);
        l0_acc = cyc + 1;
      end
      l0_pv = l0_rsp_valid;

      if (l3_rsp_valid && !l3_pv) begin
        check("l3_latency", cyc - l3_acc, 4);
        check("l3_rsp_s", l3_rsp_s, 8'd7);
      end
      if (l3_req_ready) begin
        if (l3_acc >= 0) check("l3_accept_spacing", cyc + 1 - l3_acc, 6);
        l3_acc = cyc + 1;
      end
      l3_pv = l3_rsp_valid;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] s;
    logic [2:0]   op;
    logic [15:0]  cnt;   // op_count while the response is presented
    int           acc;   // cycle index of the accept edge
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt = 16'd0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_rsp", 1, 0);
        else                check("rsp_latency", cyc - sb[0].acc, 2);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_handshake", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_s", rsp_s, e.s);
          check("rsp_op", rsp_op, e.op);
          check("op_count_at_rsp", op_count, e.cnt);
`ifdef ULA_CTRL_FLAGS_EN
          check("rsp_zero", rsp_zero, (e.s == '0));
          check("rsp_neg", rsp_neg, e.s[W-1]);
`endif
        end
      end
      prev_valid = rsp_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic [W-1:0] exp_s, input bit push);
    int n = 0;
    int acc;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 0, 1);
    end else begin
      req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
      acc = cyc + 1;
      @(negedge clk);
      req_valid = 1'b0;
      if (push) begin
        sb.push_back('{s: exp_s, op: op, cnt: exp_cnt, acc: acc});
        exp_cnt++;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || rsp_valid) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic [W-1:0] s;
  } vec_t;

  vec_t vecs[5] = '{
    '{a: 8'd5,   b: 8'd10,  op: 3'b001, s: 8'hFB},
    '{a: 8'd7,   b: 8'd7,   op: 3'b001, s: 8'h00},
    '{a: 8'd200, b: 8'd100, op: 3'b000, s: 8'h2C},
    '{a: 8'hF3,  b: 8'h3C,  op: 3'b010, s: 8'h30},
    '{a: 8'h12,  b: 8'h34,  op: 3'b110, s: 8'h26}
  };

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_op = 3'd0;
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_s", rsp_s, 0);
    check("rst_ula_a", ula_a, 0);
    check("rst_op_count", op_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    // basic add
    do_req(8'd5, 8'd10, ULA_ADD, 8'd15, 1);
    drain();
    check("op_count_after_first", op_count, 1);

    // directed vectors
    foreach (vecs[i]) do_req(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].s, 1);
    drain();
    check("op_count_after_vectors", op_count, 6);

    // stall in DONE while the source keeps poking the request side
    rsp_ready = 1'b0;
    do_req(8'h40, 8'h02, ULA_ADD, 8'h42, 1);
    begin
      int n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!rsp_valid) check("hold_rsp_timeout", 0, 1);
    end
    for (int i = 0; i < 5; i++) begin
      req_valid = ~req_valid;
      req_a     = req_a + 8'd17;
      @(negedge clk);
      check("hold_rsp_s", rsp_s, 8'h42);
      check("hold_req_ready", req_ready, 0);
      check("hold_ula_a", ula_a, 8'h40);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_op_count", op_count, 6);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check("op_count_after_hold", op_count, 7);

    // asynchronous reset while the operation is waiting on the ULA
    do_req(8'd1, 8'd1, ULA_ADD, 8'd2, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", rsp_valid, 0);
    check("async_rst_ula_a", ula_a, 0);
    check("async_rst_ula_op", ula_op, 0);
    check("async_rst_rsp_s", rsp_s, 0);
    check("async_rst_op_count", op_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'd0;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    do_req(8'd9, 8'd6, ULA_SUB, 8'd3, 1);
    drain();
    check("op_count_after_rst", op_count, 1);

    // counter wrap
    @(negedge clk);
    force u_dut.op_count = 16'hFFFF;
    #1 release u_dut.op_count;
    exp_cnt = 16'hFFFF;
    do_req(8'd1, 8'd2, ULA_ADD, 8'd3, 1);
    drain();
    check("op_count_wrap", op_count, 0);

    // back-to-back streams on the LAT=0 and LAT=3 instances
    @(posedge clk);
    #2 aux_run = 1'b1;
    repeat (40) @(posedge clk);
    #2 aux_run = 1'b0;
    repeat (8) @(negedge clk);
    check("l0_ops_done", (l0_op_count >= 16'd12) ? 1 : 0, 1);
    check("l3_ops_done", (l3_op_count >= 16'd6) ? 1 : 0, 1);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ula_ctrl.md
# ula_ctrl

Operation controller that owns the initiator side of the `ula` operand/opcode interface. It accepts one operation request at a time over a valid/ready handshake and drives `a`, `b` and `opcode` into the ULA. It waits a fixed, parameterised ULA latency, captures `s`, and returns the result over a second valid/ready handshake. It sits between a request source (sequencer or test host) and the `ula` instance, and replaces ad-hoc stimulus driving with a cycle-exact hardware protocol.

## Interface
- `WIDTH`, 8, operand/result width; must match the ULA.
- `LAT`, 1, ULA result latency in clock edges after operands change; legal range 0..7.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  controller can accept a request.
- `req_a`, `req_b`  input  WIDTH  operands.
- `req_op`  input  3  ULA opcode (000 add, 001 sub, others passed through unchanged).
- `ula_a`, `ula_b`  output  WIDTH  registered operands to the ULA `a`/`b`.
- `ula_op`  output  3  registered opcode to the ULA `opcode`.
- `ula_s`  input  WIDTH  ULA result `s`.
- `rsp_valid`  output  1  result available.
- `rsp_ready`  input  1  consumer takes the result.
- `rsp_s`  output  WIDTH  captured result.
- `rsp_op`  output  3  opcode that produced `rsp_s`.
- `op_count`  output  16  completed operations.
- `rsp_zero`, `rsp_neg`  output  1 each  flags; present only with `ULA_CTRL_FLAGS_EN`.

## Operation
- States: IDLE, WAIT, DONE. Reset state IDLE.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, load `ula_a/ula_b/ula_op` from the request, clear `wcnt`, go to WAIT.
- WAIT: `req_ready`=0. `ula_*` are held stable. When `wcnt == LAT`, capture `ula_s` into `rsp_s`, copy `ula_op` into `rsp_op`, and go to DONE; otherwise increment `wcnt` (3 bits).
- DONE: `rsp_valid`=1, `req_ready`=0. `rsp_s`/`rsp_op` are held stable until `rsp_ready`. On `rsp_valid && rsp_ready`, increment `op_count` and go to IDLE.
- `op_count` wraps 0xFFFF -> 0x0000 and increments only on a response handshake.
- `ula_*` keep their last values in IDLE and DONE; they change only on request acceptance.
- `req_valid` outside IDLE is ignored. Requests are not queued, so the source must hold the request until `req_ready`.
- `rsp_ready` outside DONE is ignored.
- Results are not interpreted; `rsp_s` is the raw WIDTH-bit ULA output (mod 2^WIDTH).

## Timing
- Reset (async assert, sync release): state IDLE, `req_ready`=1 once `rst` is low, `rsp_valid`=0, `rsp_s`=0, `rsp_op`=0, `ula_a`=`ula_b`=0, `ula_op`=0, `op_count`=0, flags 0, `wcnt`=0.
- Accept edge E0: `ula_*` valid after E0.
- Capture occurs on edge E(LAT+1). `rsp_valid` rises after that edge, so request-to-response latency is LAT+1 cycles. LAT=0 captures on E1.
- Throughput: one operation per LAT+3 cycles minimum with `rsp_ready` held high (accept, LAT+1 WAIT cycles, DONE cycle). The DONE-to-IDLE turnaround does not overlap with a new accept.
- Reset asserted mid-WAIT or mid-DONE: the in-flight operation is discarded, `op_count` is not incremented, and all outputs go immediately to their reset values.

## Configuration
- `ULA_CTRL_FLAGS_EN` defined: `rsp_zero` = (captured `ula_s` == 0) and `rsp_neg` = captured `ula_s[WIDTH-1]`. Both are registered on the capture edge alongside `rsp_s` and reset to 0.
- Not defined: the `rsp_zero`/`rsp_neg` ports and their registers do not exist. All other behaviour is identical.

## Structure
- A shared package `ula_pkg` holds the opcode constants (`ULA_ADD`=3'b000, `ULA_SUB`=3'b001), the state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), and the default WIDTH.
- One natural sub-module: `ula_ctrl_wait`, the LAT latency counter, with `start` and `hit` signals.
- The `ula` instance lives outside this block. The bench instantiates `ula` and `ula_ctrl` together.

## Test plan
- Reset, then `req` a=5, b=10, op=000 with LAT=1 and `rsp_ready`=1 -> `rsp_valid` 2 cycles after accept, `rsp_s`=15, `rsp_op`=000, `op_count`=1.
- Request a=5, b=10, op=001 -> `rsp_s`=0xFB. With `ULA_CTRL_FLAGS_EN`: `rsp_neg`=1, `rsp_zero`=0. Request a=7, b=7, op=001 -> `rsp_s`=0, `rsp_zero`=1.
- Hold `rsp_ready`=0 for 5 cycles in DONE while toggling `req_valid`/`req_a` -> `rsp_s` stable, `req_ready`=0, `ula_a` unchanged. On `rsp_ready`=1, one `op_count` increment.
- Build with LAT=0 and with LAT=3, back-to-back requests -> responses 1 and 4 cycles after accept respectively, with LAT+3 cycles between accepts.
- Assert `rst` asynchronously mid-WAIT (no clock edge) -> all outputs at reset values immediately, `op_count` stays 0, and the next request completes normally.
- Preload the count with 65535 completions (or use a forced count) -> the next response handshake gives `op_count`=0.
